// File: rtl/processador_nios2_qsys_0_mul_pkg.sv
// Shared types and constants for the nibble-serial 32x32 multiplier.
package processador_nios2_qsys_0_mul_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned NUM_NIBBLES = 8;
  localparam int unsigned K_W         = 3;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_e;

  // Captured operand pair; src2 is shifted down one nibble per issue
  typedef struct packed {
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } mul_operands_t;

  // Place a partial product at nibble position k (k*4 bits), truncated to 32 bits
  function automatic logic [DATA_W-1:0] place_term(input logic [DATA_W-1:0] p,
                                                   input logic [K_W-1:0]    k);
    return p << {k, 2'b00};
  endfunction

endpackage

// File: rtl/processador_nios2_qsys_0_mult_cell.sv
// 32x4 multiply cell: registered low 32 bits of a*b, CELL_LAT stages deep.
// Synchronous active-low clear discards all stage contents.
module processador_nios2_qsys_0_mult_cell
  import processador_nios2_qsys_0_mul_pkg::*;
#(
  parameter int unsigned CELL_LAT = 1
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  input  logic [DATA_W-1:0]   a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [DATA_W-1:0]   p
);

  logic [DATA_W-1:0] r_stage [CELL_LAT];
  logic [DATA_W-1:0] w_prod;

  // Only the low 32 bits of the product ever reach the accumulator
  assign w_prod = a * DATA_W'(b);

  // Product pipeline; stage 0 loads only on an issue cycle
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < CELL_LAT; i++) r_stage[i] <= '0;
    end else begin
      if (en) r_stage[0] <= w_prod;
      for (int unsigned i = 1; i < CELL_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign p = r_stage[CELL_LAT-1];

endmodule

// File: rtl/processador_nios2_qsys_0_mul_seq.sv
// Sequential 32x32 -> 32 unsigned multiplier issuing src2 nibbles LSB first
// to a 32x4 multiply cell and accumulating the shifted partial products.
// Optional MUL_SEQ_EARLY_EXIT_EN: stop issuing once the unissued src2 nibbles
// are all zero (at least one nibble is always issued).
module processador_nios2_qsys_0_mul_seq
  import processador_nios2_qsys_0_mul_pkg::*;
#(
  parameter int unsigned CELL_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  mul_state_e        r_state;
  mul_state_e        w_state_nxt;
  mul_operands_t     r_ops;
  logic [K_W-1:0]    r_k;
  logic [DATA_W-1:0] r_acc;
  logic              r_vld [CELL_LAT];
  logic [K_W-1:0]    r_k_d [CELL_LAT];

  logic              r_start_ready;
  logic              r_busy;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_result;

  logic              w_start_ready_nxt;
  logic              w_busy_nxt;
  logic              w_res_valid_nxt;
  logic [DATA_W-1:0] w_result_nxt;

  logic              w_accept;
  logic              w_issue;
  logic              w_last_issue;
  logic [DATA_W-1:0] w_src2_rest;
  logic [DATA_W-1:0] w_cell_p;
  logic [DATA_W-1:0] w_acc_nxt;

  assign w_accept    = start_valid && (r_state == ST_IDLE);
  assign w_issue     = (r_state == ST_RUN);
  assign w_src2_rest = r_ops.src2 >> NIBBLE_W;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // Nothing significant left to issue; also true after nibble 7
  assign w_last_issue = (w_src2_rest == '0);
`else
  assign w_last_issue = (r_k == K_W'(NUM_NIBBLES - 1));
`endif

  // Accumulate the product leaving the cell, positioned by its delayed index
  assign w_acc_nxt = r_vld[CELL_LAT-1]
                   ? r_acc + place_term(w_cell_p, r_k_d[CELL_LAT-1])
                   : r_acc;

  processador_nios2_qsys_0_mult_cell #(
    .CELL_LAT (CELL_LAT)
  ) u_cell (
    .clk   (clk),
    .clr_n (~reset),
    .en    (w_issue),
    .a     (r_ops.src1),
    .b     (r_ops.src2[NIBBLE_W-1:0]),
    .p     (w_cell_p)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_result      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_ready <= w_start_ready_nxt;
      r_busy        <= w_busy_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_result      <= w_result_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start_valid)  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last_issue) w_state_nxt = ST_DRAIN;
      ST_DRAIN:                   w_state_nxt = ST_DONE;
      ST_DONE:  if (res_ready)    w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    w_start_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt        = (w_state_nxt != ST_IDLE);
    w_res_valid_nxt   = (w_state_nxt == ST_DONE);
    w_result_nxt      = r_result;
    if (r_state == ST_DRAIN) w_result_nxt = w_acc_nxt;
  end

  // Operand capture, nibble issue, in-flight tracking and accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ops <= '0;
      r_k   <= '0;
      r_acc <= '0;
      for (int unsigned i = 0; i < CELL_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_k_d[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_ops.src1 <= src1;
        r_ops.src2 <= src2;
        r_k        <= '0;
        r_acc      <= '0;
      end else begin
        r_acc <= w_acc_nxt;
        if (w_issue) begin
          r_ops.src2 <= w_src2_rest;
          r_k        <= r_k + K_W'(1);
        end
      end
      r_vld[0] <= w_issue;
      r_k_d[0] <= r_k;
      for (int unsigned i = 1; i < CELL_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_k_d[i] <= r_k_d[i-1];
      end
    end
  end

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign result      = r_result;

endmodule

// File: tb/tb_processador_nios2_qsys_0_mul_seq.sv
// Self-checking bench for processador_nios2_qsys_0_mul_seq.
// Honours MUL_SEQ_EARLY_EXIT_EN for expected latencies.
module tb_processador_nios2_qsys_0_mul_seq;

  logic        clk;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  processador_nios2_qsys_0_mul_seq #(.CELL_LAT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .src1        (src1),
    .src2        (src2),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Latency in edges from accept to res_valid, from the operand alone
  function automatic int model_lat(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 8; i++)
      if ((b >> (4 * i)) != 32'd0) n = i + 1;
    return n + 1;
`else
    return 9;
`endif
  endfunction

  function automatic int lat_sel(input int off, input int on);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    return on;
`else
    return off;
`endif
  endfunction

  // Behavioural model: transaction-level view of the handshake and product
  bit          m_known = 1'b0;
  bit          m_idle  = 1'b1;
  bit          m_done  = 1'b0;
  int          m_cnt   = 0;
  int          m_lat   = 0;
  logic [31:0] m_exp   = '0;
  logic [31:0] m_last  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_known = 1'b1;
      m_idle  = 1'b1;
      m_done  = 1'b0;
      m_cnt   = 0;
      m_last  = '0;
    end else if (m_idle) begin
      if (start_valid) begin
        m_idle = 1'b0;
        m_cnt  = 0;
        m_lat  = model_lat(src2);
        m_exp  = 32'(64'(src1) * 64'(src2));
      end
    end else if (!m_done) begin
      m_cnt++;
      if (m_cnt == m_lat) begin
        m_done = 1'b1;
        m_last = m_exp;
      end
    end else if (res_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_known) begin
      chk("mdl_start_ready", 32'(start_ready), 32'(m_idle));
      chk("mdl_busy",        32'(busy),        32'(!m_idle));
      chk("mdl_res_valid",   32'(res_valid),   32'(m_done));
      chk("mdl_result",      result,           m_last);
    end
  end

  // One operation with literal expectations; hold = cycles res_ready stays low in DONE
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int edges = 0;
    bit got   = 1'b0;
    @(negedge clk);
    src1        = a;
    src2        = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    src1        = ~a;
    src2        = ~b;
    while (!got && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no res_valid after %0d edges, expected %0d", name, edges, exp_lat);
    end else begin
      chk({name, "_lat"},    32'(edges), 32'(exp_lat));
      chk({name, "_result"}, result,     exp_res);
    end
    for (int c = 0; c < hold; c++) begin
      start_valid = (c % 2 == 0);
      src1        = 32'h0000_0100 + 32'(c);
      src2        = 32'h0000_0003;
      @(posedge clk);
      @(negedge clk);
      chk({name, "_hold_valid"},  32'(res_valid), 32'd1);
      chk({name, "_hold_result"}, result,         exp_res);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk({name, "_idle_ready"}, 32'(start_ready), 32'd1);
    chk({name, "_idle_valid"}, 32'(res_valid),   32'd0);
    chk({name, "_idle_busy"},  32'(busy),        32'd0);
    chk({name, "_idle_result"}, result,          exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    src1        = '0;
    src2        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result",      result,           32'd0);
    chk("rst_res_valid",   32'(res_valid),   32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    reset = 1'b0;

    run_op("mul_3x5",     32'd3,          32'd5,          32'h0000_000F, lat_sel(9, 2), 1);
    run_op("mul_ffxff",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, lat_sel(9, 9), 5);
    run_op("mul_x10",     32'h1234_5678,  32'h0000_0010,  32'h2345_6780, lat_sel(9, 3), 0);
    run_op("mul_zero",    32'hCAFE_F00D,  32'h0000_0000,  32'h0000_0000, lat_sel(9, 2), 0);
    run_op("mul_ffff",    32'h0000_FFFF,  32'h0001_0001,  32'hFFFF_FFFF, lat_sel(9, 6), 0);
    run_op("mul_x100",    32'hDEAD_BEEF,  32'h0000_0100,  32'hADBE_EF00, lat_sel(9, 4), 2);

    // Reset while RUN is issuing nibble 4
    @(negedge clk);
    src1        = 32'h1111_1111;
    src2        = 32'h2222_2222;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_result",      result,           32'd0);
    chk("mid_rst_res_valid",   32'(res_valid),   32'd0);
    chk("mid_rst_busy",        32'(busy),        32'd0);
    chk("mid_rst_start_ready", 32'(start_ready), 32'd1);
    reset = 1'b0;

    run_op("mul_7x6", 32'd7, 32'd6, 32'd42, lat_sel(9, 2), 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/processador_nios2_qsys_0_mul_seq.md
PROCESSADOR_NIOS2_QSYS_0_MUL_SEQ -- requirements
Module: processador_nios2_qsys_0_mul_seq

Interface
REQ-001 SHALL have parameter CELL_LAT, default 1, meaning the multiply-cell output latency in cycles; only 1 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start_valid, input, 1, meaning an operand pair is offered.
REQ-005 SHALL have port start_ready, output, 1, meaning the block accepts operands this cycle.
REQ-006 SHALL have port src1, input, 32, the multiplicand.
REQ-007 SHALL have port src2, input, 32, the multiplier.
REQ-008 SHALL have port res_valid, output, 1, meaning result is valid.
REQ-009 SHALL have port res_ready, input, 1, meaning the consumer takes result.
REQ-010 SHALL have port result, output, 32, the low 32 bits of src1*src2, unsigned.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL compute result = (src1*src2) mod 2^32 by issuing src2 nibbles, LSB first, to the 32x4 multiply cell.
REQ-013 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-014 SHALL drive start_ready = 1 only in IDLE; a start_valid seen in any other state SHALL be ignored.
REQ-015 SHALL, on a start_valid && start_ready edge, capture src1 and src2, clear the accumulator and nibble index k, and enter RUN.
REQ-016 SHALL, in RUN, drive the cell with the captured src1 and with the current src2 nibble; each cycle it SHALL shift the src2 copy right by 4 and increment k.
REQ-017 SHALL track in-flight products with a 1-bit valid pipe and a delayed index k_d.
REQ-018 SHALL, while that valid bit is high, perform acc <= acc + ((cell_result << 4*k_d) truncated to 32 bits).
REQ-019 SHALL go from RUN to DRAIN after the cycle that issues nibble 7 (k=7).
REQ-020 SHALL spend one cycle in DRAIN accumulating the last product, then enter DONE.
REQ-021 SHALL, in DONE, hold res_valid=1 and result=acc stable until res_ready=1, then enter IDLE on that edge.
REQ-022 SHALL have a latency of exactly 9 rising edges from the accepting edge to res_valid rising, when the macro is absent.
REQ-023 SHALL keep result stable and res_valid low outside DONE; result holds the last value.
REQ-024 SHALL have throughput of one operation per 9 cycles plus the DONE handshake cycles plus 1 IDLE cycle.

Reset
REQ-025 SHALL, on reset (including mid-operation), set the state to IDLE, res_valid=0, result=0, acc=0, k=0, the valid pipe to 0 and busy=0, with start_ready=1 after the reset cycle.
REQ-026 SHALL drive the cell's active-low clear with ~reset, so that cell contents are discarded.

Configuration
REQ-027 SHALL, when macro MUL_SEQ_EARLY_EXIT_EN is defined, leave RUN for DRAIN after any issue cycle in which the shifted src2 copy (the nibbles not yet issued) is zero.
REQ-028 SHALL, with that macro defined, issue at least one nibble; latency SHALL be n+1 edges, where n = max(1, number of significant src2 nibbles).
REQ-029 SHALL, without the macro, always issue 8 nibbles; results SHALL be identical in both builds.

Structure
REQ-030 SHALL place the state enum, NIBBLE_W=4 and NUM_NIBBLES=8 in shared package processador_nios2_qsys_0_mul_pkg.
REQ-031 SHALL instantiate exactly one sub-module, processador_nios2_qsys_0_mult_cell, as the datapath; the controller SHALL contain no multiplier of its own.

Verification
REQ-032 SHALL cover: src1=3, src2=5 -> result=0x0000000F, res_valid 9 edges after accept (macro off).
REQ-033 SHALL cover: src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0x00000001.
REQ-034 SHALL cover: src1=0x12345678, src2=0x00000010 -> result=0x23456780; with the macro on, latency is 3 edges.
REQ-035 SHALL cover: src2=0, macro on -> result=0 after 2 edges; macro off -> result=0 after 9 edges.
REQ-036 SHALL cover: res_ready held low 5 cycles in DONE -> result and res_valid stable, start_valid pulses ignored; IDLE follows the res_ready edge.
REQ-037 SHALL cover: reset asserted in RUN at k=4 -> next cycle IDLE, result=0, res_valid=0; a new op 7*6 then yields 42.
